// File: rtl/prio_dec_accum.sv
// Rebuilds a WIDTH-bit mask from a stream of bit indices. Latency: 1 cycle from the in_last handshake to out_valid.
// Backpressure: the frame is held until out_ready; in_ready stays low while a frame is held.
module prio_dec_accum #(
    parameter int WIDTH_LOG = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             in_idx,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [(1<<WIDTH_LOG)-1:0] out_mask,
    output logic [WIDTH_LOG:0]     out_count,
    output logic                   out_err
);
    localparam int WIDTH = 1 << WIDTH_LOG;
    localparam logic [8:0] WIDTH_9 = 9'(WIDTH);

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_in_ready;
    logic [WIDTH-1:0]       r_mask;
    logic [WIDTH-1:0]       w_mask_nxt;
    logic [WIDTH_LOG:0]     r_count;
    logic [WIDTH_LOG:0]     w_count_nxt;
    logic                   r_err;
    logic                   w_err_nxt;

    logic                   w_in_range;
    logic [WIDTH_LOG-1:0]   w_bit_idx;
    logic [WIDTH-1:0]       w_onehot;

    assign w_in_range = ({1'b0, in_idx} < WIDTH_9);
    assign w_bit_idx  = in_idx[WIDTH_LOG-1:0];
    assign w_onehot   = {{(WIDTH-1){1'b0}}, 1'b1} << w_bit_idx;

    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        w_count_nxt = r_count;
        w_err_nxt   = r_err;
        case (r_state)
            ST_ACCUM: begin
                if (in_valid && r_in_ready) begin
                    if (w_in_range) begin
                        // Duplicate indices leave mask and count untouched.
                        if (!r_mask[w_bit_idx]) begin
                            w_mask_nxt  = r_mask | w_onehot;
                            w_count_nxt = r_count + {{WIDTH_LOG{1'b0}}, 1'b1};
                        end
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                    if (in_last) begin
                        w_state_nxt = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    w_mask_nxt  = '0;
                    w_count_nxt = '0;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = ST_ACCUM;
                end
            end
            default: begin
                w_state_nxt = ST_ACCUM;
            end
        endcase
    end

    // in_ready is its own register so it stays low while reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_ACCUM;
            r_in_ready <= 1'b0;
            r_mask     <= '0;
            r_count    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt == ST_ACCUM);
            r_mask     <= w_mask_nxt;
            r_count    <= w_count_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = (r_state == ST_HOLD);
    assign out_mask  = r_mask;
    assign out_count = r_count;
    assign out_err   = r_err;

endmodule

// File: tb/tb_prio_dec_accum.sv
// Directed bench for prio_dec_accum with WIDTH_LOG=4.
module tb_prio_dec_accum;
    localparam int WL = 4;
    localparam int W  = 1 << WL;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_idx;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_mask;
    logic [WL:0]   out_count;
    logic          out_err;

    int n_checks;
    int n_fail;
    int q[$];

    prio_dec_accum #(.WIDTH_LOG(WL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_idx    (in_idx),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mask  (out_mask),
        .out_count (out_count),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic int prio_enc(input logic [W-1:0] m);
        int r;
        r = -1;
        for (int i = 0; i < W; i++) if (m[i]) r = i;
        return r;
    endfunction

    // Present one index at a negedge; returns after the handshake edge + 1.
    task automatic send_idx(input int idx, input logic last);
        int n;
        in_valid = 1'b1;
        in_idx   = 8'(idx);
        in_last  = last;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
    endtask

    // Sends the queued frame, checking out_valid latency around the last index.
    task automatic send_frame(input string tag);
        for (int i = 0; i < q.size(); i++) begin
            if (i == q.size() - 1) chk({tag, "_vld_before_last"}, 32'(out_valid), 32'd0);
            in_valid = 1'b1;
            in_idx   = 8'(q[i]);
            in_last  = (i == q.size() - 1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
            if (i == q.size() - 1) chk({tag, "_vld_lat1"}, 32'(out_valid), 32'd1);
            @(negedge clk);
        end
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_vld_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
    endtask

    task automatic check_out(input string tag, input logic [W-1:0] m,
                             input int c, input logic e);
        chk({tag, "_mask"}, 32'(out_mask), 32'(m));
        chk({tag, "_count"}, 32'(out_count), 32'(c));
        chk({tag, "_err"}, 32'(out_err), 32'(e));
    endtask

    initial begin
        int idx;
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_idx    = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #22;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        check_out("rst", 16'h0000, 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        q = '{3, 7, 0};
        send_frame("t1");
        check_out("t1", 16'h0089, 3, 1'b0);
        consume("t1");

        q = '{5, 5, 5};
        send_frame("t2");
        check_out("t2", 16'h0020, 1, 1'b0);
        consume("t2");

        q = '{2, 200};
        send_frame("t3");
        check_out("t3", 16'h0004, 1, 1'b1);
        consume("t3");
        q = '{1};
        send_frame("t3b");
        check_out("t3b", 16'h0002, 1, 1'b0);
        consume("t3b");

        q = {};
        for (int i = 15; i >= 0; i--) q.push_back(i);
        send_frame("t4");
        check_out("t4", 16'hFFFF, 16, 1'b0);
        chk("t4_in_ready_hold", 32'(in_ready), 32'd0);

        // Frame held while the source keeps offering an index.
        in_valid = 1'b1;
        in_idx   = 8'd1;
        in_last  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t5_in_ready", 32'(in_ready), 32'd0);
            chk("t5_vld", 32'(out_valid), 32'd1);
            chk("t5_mask", 32'(out_mask), 32'h0000FFFF);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_out("t5_end", 16'hFFFF, 16, 1'b0);
        consume("t5");
        q = '{4};
        send_frame("t5b");
        check_out("t5b", 16'h0010, 1, 1'b0);
        consume("t5b");

        // Reset in the middle of a frame.
        send_idx(6, 1'b0);
        send_idx(11, 1'b0);
        chk("t6_partial_mask", 32'(out_mask), 32'h00000840);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_vld", 32'(out_valid), 32'd0);
        check_out("t6_rst", 16'h0000, 0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        q = '{9};
        send_frame("t6b");
        check_out("t6b", 16'h0200, 1, 1'b0);
        consume("t6b");

        q = '{14, 250};
        send_frame("t7");
        check_out("t7", 16'h4000, 1, 1'b1);
        consume("t7");
        q = '{16};
        send_frame("t7b");
        check_out("t7b", 16'h0000, 0, 1'b1);
        consume("t7b");

        for (int k = 0; k < 8; k++) begin
            idx = int'($urandom_range(0, W - 1));
            q = '{idx};
            send_frame("rt");
            chk("rt_prio_enc", 32'(prio_enc(out_mask)), 32'(idx));
            consume("rt");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
